// File: rtl/control_unit.sv
// control_unit: registered main decoder, opcode -> datapath controls.
// Ports: clk, reset (async, active-high), opcode[2:0], stall, flush in;
//   aluSelect, regSelect, immSelect, dataSelect, muxSelect, jumpSelect,
//   illegal out. Define CONTROL_UNIT_ILLEGAL_TRAP_EN for the illegal flag.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       stall,
  input  logic       flush,
  output logic       aluSelect,
  output logic       regSelect,
  output logic       immSelect,
  output logic       dataSelect,
  output logic       muxSelect,
  output logic       jumpSelect,
  output logic       illegal
);

  typedef struct packed {
    logic alu;
    logic rw;
    logic imm;
    logic dw;
    logic mux;
    logic jmp;
  } ctrl_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_JUMP = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;

  ctrl_t dec;
  ctrl_t q;

  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP:  dec = '0;
      OP_LW:   dec = 6'b011010;
      OP_SW:   dec = 6'b001100;
      OP_JUMP: dec = 6'b000001;
      OP_ADD:  dec = 6'b010000;
      OP_ADDI: dec = 6'b011000;
      OP_SUB:  dec = 6'b110000;
      default: dec = '0;
    endcase
  end

  // Flush wins over stall; stall holds the word as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (flush)
      q <= '0;
    else if (!stall)
      q <= dec;
  end

  assign aluSelect  = q.alu;
  assign regSelect  = q.rw;
  assign immSelect  = q.imm;
  assign dataSelect = q.dw;
  assign muxSelect  = q.mux;
  assign jumpSelect = q.jmp;

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
  logic ill_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ill_q <= 1'b0;
    else if (flush)
      ill_q <= 1'b0;
    else if (!stall)
      ill_q <= (opcode == 3'b111);
  end

  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed + random check of control_unit against
// a table-driven reference model (honours CONTROL_UNIT_ILLEGAL_TRAP_EN).
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic [2:0] opcode;
  logic       stall;
  logic       flush;
  logic       aluSelect;
  logic       regSelect;
  logic       immSelect;
  logic       dataSelect;
  logic       muxSelect;
  logic       jumpSelect;
  logic       illegal;

  int n_assert;
  int n_fail;

  // Reference words alu/reg/imm/data/mux/jump, indexed by opcode.
  logic [5:0] tab [8];
  logic [5:0] m_word;
  logic       m_ill;
  logic       trap_en;

  control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .stall      (stall),
    .flush      (flush),
    .aluSelect  (aluSelect),
    .regSelect  (regSelect),
    .immSelect  (immSelect),
    .dataSelect (dataSelect),
    .muxSelect  (muxSelect),
    .jumpSelect (jumpSelect),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {aluSelect, regSelect, immSelect,
            dataSelect, muxSelect, jumpSelect, illegal};
  endfunction

  task automatic check(input string tag,
                       input logic [6:0] exp);
    logic [6:0] got;
    got = obs();
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic [2:0] op,
                            input logic st,
                            input logic fl);
    if (fl) begin
      m_word = '0;
      m_ill  = 1'b0;
    end else if (!st) begin
      m_word = tab[op];
      m_ill  = trap_en && (op == 3'd7);
    end
  endtask

  task automatic cyc(input string tag,
                     input logic [2:0] op,
                     input logic st,
                     input logic fl);
    opcode = op;
    stall  = st;
    flush  = fl;
    @(posedge clk);
    model_edge(op, st, fl);
    #1;
    check(tag, {m_word, m_ill});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    tab[0] = 6'b000000;
    tab[1] = 6'b011010;
    tab[2] = 6'b001100;
    tab[3] = 6'b000001;
    tab[4] = 6'b010000;
    tab[5] = 6'b011000;
    tab[6] = 6'b110000;
    tab[7] = 6'b000000;
    m_word = '0;
    m_ill  = 1'b0;

    reset  = 1'b1;
    opcode = 3'b001;
    stall  = 1'b0;
    flush  = 1'b0;
    #1;
    check("reset_async", 7'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 7'b0);
    #2;
    reset = 1'b0;

    cyc("lw_after_reset", 3'd1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_cycle", 7'b0);
    m_word = '0;
    m_ill  = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;

    cyc("sweep_lw", 3'd1, 1'b0, 1'b0);
    cyc("sweep_sw", 3'd2, 1'b0, 1'b0);
    cyc("sweep_jump", 3'd3, 1'b0, 1'b0);
    cyc("sweep_add", 3'd4, 1'b0, 1'b0);
    cyc("sweep_addi", 3'd5, 1'b0, 1'b0);
    cyc("sweep_sub", 3'd6, 1'b0, 1'b0);

    cyc("stall_1", 3'd3, 1'b1, 1'b0);
    cyc("stall_2", 3'd3, 1'b1, 1'b0);
    cyc("stall_3", 3'd3, 1'b1, 1'b0);
    cyc("stall_release", 3'd3, 1'b0, 1'b0);

    cyc("pre_flush_lw", 3'd1, 1'b0, 1'b0);
    cyc("flush_over_stall", 3'd1, 1'b1, 1'b1);

    cyc("illegal_set", 3'd7, 1'b0, 1'b0);
    cyc("illegal_stall", 3'd2, 1'b1, 1'b0);
    cyc("illegal_clear", 3'd4, 1'b0, 1'b0);
    cyc("illegal_again", 3'd7, 1'b0, 1'b0);
    cyc("illegal_flush", 3'd7, 1'b0, 1'b1);

    cyc("addi_then", 3'd5, 1'b0, 1'b0);
    cyc("nop_after_addi", 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      logic st;
      logic fl;
      op = 3'($urandom_range(0, 7));
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      cyc("random", op, st, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
